alu_instr_sequencer: RTL

- Parametrised control sequencer for the Phase-1 datapath.
- Sequences one register-register ALU instruction autonomously from a start pulse: fetch (T0-T2), operand (T3-T4), writeback (T5, plus T6 for wide ops).
- Drives the datapath's one-hot enable/bus-select vectors and 4-bit ALU control code.
- Generalises the per-instruction hand-written sequences: any opcode, any register triple, two-word results (MUL/DIV) to LO/HI.

---
 rtl/alu_instr_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_instr_sequencer.sv
// Control sequencer that runs one register-register ALU instruction (fetch, operand, writeback) from a start pulse.
// Optional build macro MEM_WAIT_EN: T1 stretches until mem_ready is high.
module alu_instr_sequencer #(
  parameter int SEL_W    = 32,
  parameter int NUM_REGS = 16,
  parameter int RIDX_W   = 4,
  parameter int OP_MUL   = 12,
  parameter int OP_DIV   = 13,
  parameter int B_HI     = 16,
  parameter int B_LO     = 17,
  parameter int B_ZHI    = 18,
  parameter int B_ZLO    = 19,
  parameter int B_PC     = 20,
  parameter int B_MDR    = 21,
  parameter int B_IR     = 23,
  parameter int B_Z      = 24,
  parameter int B_MAR    = 25,
  parameter int B_Y      = 27
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [RIDX_W-1:0] ra,
  input  logic [RIDX_W-1:0] rb,
  input  logic [RIDX_W-1:0] rc,
  input  logic              mem_ready,
  output logic [SEL_W-1:0]  enable,
  output logic [SEL_W-1:0]  bus_select,
  output logic [3:0]        alu_ctrl,
  output logic              mem_read,
  output logic              pc_inc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // state  | meaning
  // S_IDLE | waiting for start, all outputs low
  // S_T0   | PC -> MAR, increment PC
  // S_T1   | memory read into MDR
  // S_T2   | MDR -> IR
  // S_T3   | ra -> Y
  // S_T4   | rb -> ALU, result into Z
  // S_T5   | ZLO -> rc (normal) or LO (wide)
  // S_T6   | ZHI -> HI (wide ops only)
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  localparam logic [3:0] OP_MUL_C = 4'(OP_MUL);
  localparam logic [3:0] OP_DIV_C = 4'(OP_DIV);

  state_t            state_q, state_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [RIDX_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [SEL_W-1:0]  enable_q, enable_d, bus_select_q, bus_select_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic              mem_read_q, mem_read_d, pc_inc_q, pc_inc_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic wide_in, wide_q, start_legal;

`ifndef MEM_WAIT_EN
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
`endif

  function automatic logic [SEL_W-1:0] onehot(input logic [RIDX_W-1:0] idx);
    onehot = {{(SEL_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign wide_in     = (opcode == OP_MUL_C) || (opcode == OP_DIV_C);
  assign wide_q      = (opcode_q == OP_MUL_C) || (opcode_q == OP_DIV_C);
  // rc is never written by a wide op, so its range is irrelevant there
  assign start_legal = (int'(ra) < NUM_REGS) && (int'(rb) < NUM_REGS) &&
                       (wide_in || (int'(rc) < NUM_REGS));

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_legal) begin
            state_d  = S_T0;
            opcode_d = opcode;
            ra_d     = ra;
            rb_d     = rb;
            rc_d     = rc;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_T0: state_d = S_T1;
      S_T1: begin
`ifdef MEM_WAIT_EN
        if (mem_ready) state_d = S_T2;
`else
        state_d = S_T2;
`endif
      end
      S_T2: state_d = S_T3;
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: state_d = wide_q ? S_T6 : S_IDLE;
      S_T6: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they are registered yet aligned with it.
  always_comb begin
    enable_d     = '0;
    bus_select_d = '0;
    alu_ctrl_d   = 4'd0;
    mem_read_d   = 1'b0;
    pc_inc_d     = 1'b0;
    done_d       = 1'b0;
    busy_d       = (state_d != S_IDLE);
    case (state_d)
      S_T0: begin
        bus_select_d[B_PC] = 1'b1;
        enable_d[B_MAR]    = 1'b1;
        pc_inc_d           = 1'b1;
      end
      S_T1: begin
        mem_read_d      = 1'b1;
        enable_d[B_MDR] = 1'b1;
      end
      S_T2: begin
        bus_select_d[B_MDR] = 1'b1;
        enable_d[B_IR]      = 1'b1;
      end
      S_T3: begin
        bus_select_d  = onehot(ra_d);
        enable_d[B_Y] = 1'b1;
      end
      S_T4: begin
        bus_select_d  = onehot(rb_d);
        enable_d[B_Z] = 1'b1;
        alu_ctrl_d    = opcode_d;
      end
      S_T5: begin
        bus_select_d[B_ZLO] = 1'b1;
        alu_ctrl_d          = opcode_d;
        if ((opcode_d == OP_MUL_C) || (opcode_d == OP_DIV_C)) begin
          enable_d[B_LO] = 1'b1;
        end else begin
          enable_d = onehot(rc_d);
          done_d   = 1'b1;
        end
      end
      S_T6: begin
        bus_select_d[B_ZHI] = 1'b1;
        enable_d[B_HI]      = 1'b1;
        alu_ctrl_d          = opcode_d;
        done_d              = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_IDLE;
      opcode_q     <= 4'd0;
      ra_q         <= '0;
      rb_q         <= '0;
      rc_q         <= '0;
      enable_q     <= '0;
      bus_select_q <= '0;
      alu_ctrl_q   <= 4'd0;
      mem_read_q   <= 1'b0;
      pc_inc_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      rc_q         <= rc_d;
      enable_q     <= enable_d;
      bus_select_q <= bus_select_d;
      alu_ctrl_q   <= alu_ctrl_d;
      mem_read_q   <= mem_read_d;
      pc_inc_q     <= pc_inc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign enable     = enable_q;
  assign bus_select = bus_select_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign mem_read   = mem_read_q;
  assign pc_inc     = pc_inc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
